// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//    Receive buffer that sits directly after the UART receiver. A rising edge on
//    rx_ready_i captures one byte: a byte flagged with rx_error_i is dropped and
//    counted in err_cnt_o; any other byte is pushed into a first-word-fall-through
//    FIFO. A byte that arrives while the FIFO is full and nothing is popped is
//    dropped, and the sticky overflow_o flag is set.
//
// Ports
//    clk50m       in   system clock
//    rst_n        in   asynchronous reset, active low
//    rx_data_i    in   byte from the receiver
//    rx_ready_i   in   byte-complete flag (pulse or level); one capture per rising edge
//    rx_error_i   in   framing-error flag, qualifies the byte on the rx_ready_i edge
//    flush_i      in   synchronous FIFO clear
//    rd_en_i      in   pop request from the consumer
//    ovf_clr_i    in   clears overflow_o
//    dout_o       out  head-of-FIFO data, 0 while empty
//    dout_valid_o out  FIFO not empty
//    full_o       out  count_o == DEPTH
//    count_o      out  number of stored bytes, 0..DEPTH
//    overflow_o   out  sticky: a good byte was dropped because the FIFO was full
//    err_cnt_o    out  saturating count of bytes dropped for rx_error_i
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk50m,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           rx_data_i,
   input  logic                       rx_ready_i,
   input  logic                       rx_error_i,
   input  logic                       flush_i,
   input  logic                       rd_en_i,
   input  logic                       ovf_clr_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       dout_valid_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o,
   output logic [7:0]                 err_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic          rx_ready_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    err_cnt_q,  err_cnt_d;

   logic ev;
   logic wr;
   logic pop;
   logic full;
   logic wr_ok;
   logic ovf_ev;

   assign ev    = rx_ready_i & ~rx_ready_q;
   assign wr    = ev & ~rx_error_i;
   assign full  = (count_q == CW'(DEPTH));
   assign pop   = rd_en_i & (count_q != '0);
   // When full, a same-cycle pop frees the head slot, which is exactly where
   // wr_ptr points, so the new byte can take it without losing the old head.
   assign wr_ok  = wr & (~full | pop);
   assign ovf_ev = wr & full & ~pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      err_cnt_d  = err_cnt_q;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
         if (wr_ok && !pop)      count_d = count_q + CW'(1);
         else if (pop && !wr_ok) count_d = count_q - CW'(1);
      end

      // A same-cycle overflow event outranks the clear.
      if (ovf_ev)         overflow_d = 1'b1;
      else if (ovf_clr_i) overflow_d = 1'b0;

      if (ev && rx_error_i && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         rx_ready_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         rx_ready_q <= rx_ready_i;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Storage is not reset so it can map onto distributed/block RAM.
   always_ff @(posedge clk50m) begin
      if (wr_ok && !flush_i) mem[wr_ptr_q] <= rx_data_i;
   end

   assign dout_valid_o = (count_q != '0);
   assign dout_o       = dout_valid_o ? mem[rd_ptr_q] : '0;
   assign full_o       = full;
   assign count_o      = count_q;
   assign overflow_o   = overflow_q;
   assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo with DEPTH = 4. Inputs change on the
// falling edge and outputs are checked on the falling edge.
module tb_uart_rx_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk50m = 1'b0;
   logic             rst_n  = 1'b0;
   logic [WIDTH-1:0] rx_data = '0;
   logic             rx_ready = 1'b0;
   logic             rx_error = 1'b0;
   logic             flush = 1'b0;
   logic             rd_en = 1'b0;
   logic             ovf_clr = 1'b0;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             full;
   logic [CW-1:0]    count;
   logic             overflow;
   logic [7:0]       err_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #10 clk50m = ~clk50m;

   uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk50m      (clk50m),
      .rst_n       (rst_n),
      .rx_data_i   (rx_data),
      .rx_ready_i  (rx_ready),
      .rx_error_i  (rx_error),
      .flush_i     (flush),
      .rd_en_i     (rd_en),
      .ovf_clr_i   (ovf_clr),
      .dout_o      (dout),
      .dout_valid_o(dout_valid),
      .full_o      (full),
      .count_o     (count),
      .overflow_o  (overflow),
      .err_cnt_o   (err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %s got=%0h", tag, got);
      end else begin
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One rx_ready pulse; returns on the falling edge after the capture edge.
   task automatic send(input logic [7:0] d, input logic err);
      @(negedge clk50m);
      rx_data  = d;
      rx_error = err;
      rx_ready = 1'b1;
      @(negedge clk50m);
      rx_ready = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk50m);
      rd_en = 1'b1;
      @(negedge clk50m);
      rd_en = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge clk50m);
      flush = 1'b1;
      @(negedge clk50m);
      flush = 1'b0;
   endtask

   logic [7:0] exp_a [4];

   initial begin
      // Reset state
      #5;
      check("rst_count", 32'(count), 0);
      check("rst_valid", 32'(dout_valid), 0);
      check("rst_dout", 32'(dout), 0);
      check("rst_err", 32'(err_cnt), 0);
      check("rst_ovf", 32'(overflow), 0);
      @(negedge clk50m);
      rst_n = 1'b1;

      // 1: single byte, rx_ready held high
      @(negedge clk50m);
      rx_data  = 8'hA5;
      rx_ready = 1'b1;
      @(negedge clk50m);
      check("t1_dout_next", 32'(dout), 32'hA5);
      check("t1_valid_next", 32'(dout_valid), 1);
      repeat (9) @(negedge clk50m);
      check("t1_count_held", 32'(count), 1);
      rx_ready = 1'b0;
      pop_one();
      check("t1_count_pop", 32'(count), 0);
      check("t1_valid_pop", 32'(dout_valid), 0);
      check("t1_dout_empty", 32'(dout), 0);
      // rd_en while empty is ignored
      pop_one();
      check("t1_empty_pop", 32'(count), 0);

      // 2: framing errors
      send(8'h3C, 1'b1);
      check("t2_count", 32'(count), 0);
      check("t2_err1", 32'(err_cnt), 1);
      repeat (299) send(8'h3C, 1'b1);
      check("t2_err_sat", 32'(err_cnt), 255);
      check("t2_count_after", 32'(count), 0);

      // 3: fill and overflow
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      check("t3_full", 32'(full), 1);
      check("t3_count4", 32'(count), 4);
      check("t3_ovf_before", 32'(overflow), 0);
      send(8'h55, 1'b0);
      check("t3_ovf", 32'(overflow), 1);
      check("t3_count_ovf", 32'(count), 4);
      exp_a = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_pop%0d", i), 32'(dout), 32'(exp_a[i]));
         pop_one();
      end
      check("t3_count0", 32'(count), 0);
      @(negedge clk50m);
      ovf_clr = 1'b1;
      @(negedge clk50m);
      ovf_clr = 1'b0;
      check("t3_ovf_clr", 32'(overflow), 0);

      // 4: full with simultaneous pop
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      @(negedge clk50m);
      rx_data  = 8'h55;
      rx_ready = 1'b1;
      rd_en    = 1'b1;
      @(negedge clk50m);
      rx_ready = 1'b0;
      rd_en    = 1'b0;
      check("t4_count", 32'(count), 4);
      check("t4_ovf", 32'(overflow), 0);
      exp_a = '{8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t4_pop%0d", i), 32'(dout), 32'(exp_a[i]));
         pop_one();
      end
      check("t4_count0", 32'(count), 0);

      // 5: wrap-around, 10 rounds of write 2 / pop 2
      for (int r = 0; r < 10; r++) begin
         send(8'(2 * r), 1'b0);
         send(8'(2 * r + 1), 1'b0);
         check($sformatf("t5_r%0d_a", r), 32'(dout), 32'(2 * r));
         pop_one();
         check($sformatf("t5_r%0d_b", r), 32'(dout), 32'(2 * r + 1));
         pop_one();
      end
      check("t5_count0", 32'(count), 0);
      // ovf_clr colliding with an overflow event
      for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 1'b0);
      @(negedge clk50m);
      rx_data  = 8'hAA;
      rx_ready = 1'b1;
      ovf_clr  = 1'b1;
      @(negedge clk50m);
      rx_ready = 1'b0;
      ovf_clr  = 1'b0;
      check("t5_ovf_wins", 32'(overflow), 1);
      check("t5_head_kept", 32'(dout), 32'hC0);

      // 6: flush with same-cycle write, then async reset
      do_flush();
      check("t6_flush_count", 32'(count), 0);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      check("t6_loaded", 32'(count), 3);
      @(negedge clk50m);
      rx_data  = 8'h77;
      rx_ready = 1'b1;
      flush    = 1'b1;
      @(negedge clk50m);
      rx_ready = 1'b0;
      flush    = 1'b0;
      check("t6_count", 32'(count), 0);
      check("t6_valid", 32'(dout_valid), 0);
      check("t6_dout", 32'(dout), 0);
      check("t6_err_kept", 32'(err_cnt), 255);
      check("t6_ovf_kept", 32'(overflow), 1);
      send(8'h61, 1'b0);
      send(8'h62, 1'b0);
      check("t6_after_flush", 32'(dout), 32'h61);
      @(negedge clk50m);
      #3 rst_n = 1'b0;
      #1;
      check("t6_rst_count", 32'(count), 0);
      check("t6_rst_valid", 32'(dout_valid), 0);
      check("t6_rst_dout", 32'(dout), 0);
      check("t6_rst_full", 32'(full), 0);
      check("t6_rst_ovf", 32'(overflow), 0);
      check("t6_rst_err", 32'(err_cnt), 0);
      @(negedge clk50m);
      rst_n = 1'b1;
      send(8'h9D, 1'b0);
      check("t6_post_rst_dout", 32'(dout), 32'h9D);
      check("t6_post_rst_count", 32'(count), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
